// File: rtl/stream_packet_parser.sv
// Streaming frame parser: accepts beats, captures the header and emits 20 features per frame.
// Define PKT_PARSER_VLAN_EN to parse a single 802.1Q tag.
module stream_packet_parser #(
  parameter int DATA_W    = 64,
  parameter int FEAT_W    = 32,
  parameter int MAX_BYTES = 1518,
  parameter int HDR_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [20*FEAT_W-1:0]  m_feat,
  output logic                  m_valid,
  input  logic                  m_ready
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int HW = HDR_BYTES * 8;

  typedef enum logic [1:0] {IDLE, HDR, BODY, EMIT} state_t;

  state_t               state_q, state_d;
  logic [HW-1:0]        hdr_q, hdr_d, hdr_c;
  logic [15:0]          len_q, len_d, len_c;
  logic [15:0]          beats_q, beats_d, beats_c;
  logic [FEAT_W-1:0]    gap_q, gap_d, gapl_q, gapl_d, gap_c;
  logic [FEAT_W-1:0]    seq_q, seq_d;
  logic [20*FEAT_W-1:0] feat_q, feat_d, feat_c;
  logic                 mval_q, mval_d;
  logic [NB-1:0]        lane_en;
  logic [CW-1:0]        nbytes;
  logic [15:0]          base;
  logic [16:0]          sum;
  logic                 acc, first;

  function automatic logic [7:0] hb(input logic [HW-1:0] h, input int n);
    return h[8*n +: 8];
  endfunction

  assign s_ready = !rst && (state_q != EMIT);
  assign acc     = s_valid && s_ready;
  assign first   = acc && (state_q == IDLE);
  assign m_feat  = feat_q;
  assign m_valid = mval_q;

  // Byte accounting and header capture for the beat on the bus
  always_comb begin
    lane_en = s_last ? s_keep : '1;
    nbytes = '0;
    for (int i = 0; i < NB; i++) nbytes = nbytes + CW'(lane_en[i]);
    base    = first ? 16'd0 : len_q;
    sum     = {1'b0, base} + 17'(nbytes);
    len_c   = sum[16] ? 16'hFFFF : sum[15:0];
    beats_c = first ? 16'd1 :
              (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
    gap_c   = first ? ((gap_q == '1) ? gap_q : gap_q + FEAT_W'(1))
                    : gapl_q;
    hdr_c = first ? '0 : hdr_q;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i] && ({1'b0, base} + 17'(i) < 17'(HDR_BYTES)))
        hdr_c[8*(int'(base) + i) +: 8] = s_data[8*i +: 8];
    end
  end

  always_comb begin
    logic [15:0] et;
    logic [7:0]  proto;
    logic [7:0]  b14;
    logic        ip;
    logic        vl;
    int          o;
    int          l4;
    int          pl;
    vl = 1'b0;
`ifdef PKT_PARSER_VLAN_EN
    vl = ({hb(hdr_c, 12), hb(hdr_c, 13)} == 16'h8100);
`endif
    o     = vl ? 4 : 0;
    b14   = hb(hdr_c, 14);
    et    = {hb(hdr_c, 12 + o), hb(hdr_c, 13 + o)};
    ip    = (et == 16'h0800);
    proto = hb(hdr_c, 23 + o);
    l4    = (proto == 8'd6) ? 20 : (proto == 8'd17) ? 8 : 0;
    pl    = int'(len_c) - 34 - l4 - o;
    feat_c = '0;
    feat_c[0*FEAT_W +: FEAT_W] = FEAT_W'(ip);
    if (ip) begin
      feat_c[1*FEAT_W +: FEAT_W]  = FEAT_W'(proto);
      feat_c[2*FEAT_W +: FEAT_W]  =
        FEAT_W'({hb(hdr_c, 34 + o), hb(hdr_c, 35 + o)});
      feat_c[3*FEAT_W +: FEAT_W]  =
        FEAT_W'({hb(hdr_c, 36 + o), hb(hdr_c, 37 + o)});
      feat_c[4*FEAT_W +: FEAT_W]  =
        FEAT_W'({hb(hdr_c, 26 + o), hb(hdr_c, 27 + o),
                 hb(hdr_c, 28 + o), hb(hdr_c, 29 + o)});
      feat_c[5*FEAT_W +: FEAT_W]  =
        FEAT_W'({hb(hdr_c, 30 + o), hb(hdr_c, 31 + o),
                 hb(hdr_c, 32 + o), hb(hdr_c, 33 + o)});
      feat_c[6*FEAT_W +: FEAT_W]  = FEAT_W'(hb(hdr_c, 22 + o));
      feat_c[7*FEAT_W +: FEAT_W]  =
        FEAT_W'({hb(hdr_c, 16 + o), hb(hdr_c, 17 + o)});
      feat_c[8*FEAT_W +: FEAT_W]  =
        (proto == 8'd6) ? FEAT_W'(hb(hdr_c, 47 + o)) : '0;
      feat_c[11*FEAT_W +: FEAT_W] = FEAT_W'(hb(hdr_c, 14 + o) & 8'h0F);
      feat_c[12*FEAT_W +: FEAT_W] = FEAT_W'(hb(hdr_c, 15 + o));
      feat_c[13*FEAT_W +: FEAT_W] =
        FEAT_W'({hb(hdr_c, 20 + o), hb(hdr_c, 21 + o)});
      feat_c[15*FEAT_W +: FEAT_W] = FEAT_W'((pl < 0) ? 0 : pl);
    end
    feat_c[9*FEAT_W +: FEAT_W]  = FEAT_W'(len_c);
    feat_c[10*FEAT_W +: FEAT_W] = FEAT_W'(beats_c);
    feat_c[14*FEAT_W +: FEAT_W] =
      vl ? FEAT_W'({b14[3:0], hb(hdr_c, 15)}) : '0;
    feat_c[16*FEAT_W +: FEAT_W] = FEAT_W'(int'(len_c) > MAX_BYTES);
    feat_c[17*FEAT_W +: FEAT_W] = gap_c;
    feat_c[18*FEAT_W +: FEAT_W] = FEAT_W'(et);
    feat_c[19*FEAT_W +: FEAT_W] = seq_q;
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    beats_d = beats_q;
    gap_d   = (gap_q == '1) ? gap_q : gap_q + FEAT_W'(1);
    gapl_d  = gapl_q;
    seq_d   = seq_q;
    feat_d  = feat_q;
    mval_d  = mval_q;
    unique case (state_q)
      EMIT: begin
        if (m_ready) begin
          state_d = IDLE;
          mval_d  = 1'b0;
        end
      end
      default: begin
        if (acc) begin
          hdr_d   = hdr_c;
          len_d   = len_c;
          beats_d = beats_c;
          gapl_d  = gap_c;
          if (s_last) begin
            state_d = EMIT;
            feat_d  = feat_c;
            mval_d  = 1'b1;
            seq_d   = seq_q + FEAT_W'(1);
            gap_d   = '0;
          end else begin
            state_d = (len_c >= 16'(HDR_BYTES)) ? BODY : HDR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      beats_q <= '0;
      gap_q   <= '0;
      gapl_q  <= '0;
      seq_q   <= '0;
      feat_q  <= '0;
      mval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      beats_q <= beats_d;
      gap_q   <= gap_d;
      gapl_q  <= gapl_d;
      seq_q   <= seq_d;
      feat_q  <= feat_d;
      mval_q  <= mval_d;
    end
  end
endmodule

// File: tb/tb_stream_packet_parser.sv
// Bench for stream_packet_parser: directed frames, scoreboard of expected
// feature vectors built from the bytes driven.
module tb_stream_packet_parser;
  localparam int DW = 64;
  localparam int FW = 32;
  localparam int NB = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   s_data = '0;
  logic [NB-1:0]   s_keep = '0;
  logic            s_last = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [20*FW-1:0] m_feat;
  logic            m_valid;
  logic            m_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [7:0] frm[$];
  logic [20*FW-1:0] expq[$];
  logic [20*FW-1:0] last_feat = '0;
  logic [20*FW-1:0] e;
  time t_prev = 0;
  int seq_exp = 0;

  stream_packet_parser dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_feat(m_feat), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] b(input int n);
    if (n < frm.size() && n < 64) return frm[n];
    return 8'h00;
  endfunction

  function automatic logic [31:0] lf(input int k);
    return last_feat[k*FW +: FW];
  endfunction

  function automatic logic [20*FW-1:0] model(input int gap, input int seq);
    logic [31:0] f[20];
    logic [15:0] et;
    logic [7:0] t;
    logic [20*FW-1:0] r;
    int len, o, l4, pl;
    len = frm.size();
    o = 0;
    for (int k = 0; k < 20; k++) f[k] = 0;
    et = {b(12), b(13)};
`ifdef PKT_PARSER_VLAN_EN
    if (et == 16'h8100) begin
      o = 4;
      t = b(14);
      f[14] = {20'd0, t[3:0], b(15)};
      et = {b(16), b(17)};
    end
`endif
    f[0] = (et == 16'h0800) ? 1 : 0;
    if (et == 16'h0800) begin
      f[1] = {24'd0, b(23 + o)};
      f[2] = {16'd0, b(34 + o), b(35 + o)};
      f[3] = {16'd0, b(36 + o), b(37 + o)};
      f[4] = {b(26 + o), b(27 + o), b(28 + o), b(29 + o)};
      f[5] = {b(30 + o), b(31 + o), b(32 + o), b(33 + o)};
      f[6] = {24'd0, b(22 + o)};
      f[7] = {16'd0, b(16 + o), b(17 + o)};
      f[8] = (f[1] == 6) ? {24'd0, b(47 + o)} : 0;
      t = b(14 + o);
      f[11] = {28'd0, t[3:0]};
      f[12] = {24'd0, b(15 + o)};
      f[13] = {16'd0, b(20 + o), b(21 + o)};
      l4 = (f[1] == 6) ? 20 : (f[1] == 17) ? 8 : 0;
      pl = len - 34 - l4 - o;
      f[15] = (pl < 0) ? 0 : pl;
    end
    f[9] = (len > 65535) ? 65535 : len;
    f[10] = (len == 0) ? 1 : (len + NB - 1) / NB;
    f[16] = (len > 1518) ? 1 : 0;
    f[17] = gap;
    f[18] = {16'd0, et};
    f[19] = seq;
    for (int k = 0; k < 20; k++) r[k*FW +: FW] = f[k];
    return r;
  endfunction

  task automatic put(input int n, input logic [7:0] v);
    if (n < frm.size()) frm[n] = v;
  endtask

  task automatic build(input int len, input logic [15:0] et,
                       input logic [7:0] proto, input int vid,
                       input logic [15:0] sp, input logic [15:0] dp,
                       input logic [7:0] fl);
    int o;
    o = 0;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'(i * 7 + 3));
    if (vid >= 0) begin
      put(12, 8'h81); put(13, 8'h00);
      put(14, 8'(vid >> 8)); put(15, 8'(vid));
      o = 4;
    end
    put(12 + o, et[15:8]); put(13 + o, et[7:0]);
    if (et == 16'h0800) begin
      put(14 + o, 8'h45); put(15 + o, 8'h00);
      put(16 + o, 8'((len - 14 - o) >> 8)); put(17 + o, 8'(len - 14 - o));
      put(20 + o, 8'h40); put(21 + o, 8'h00);
      put(22 + o, 8'd64); put(23 + o, proto);
      put(26 + o, 8'd10); put(27 + o, 8'd0);
      put(28 + o, 8'd0); put(29 + o, 8'd1);
      put(30 + o, 8'd10); put(31 + o, 8'd0);
      put(32 + o, 8'd0); put(33 + o, 8'd2);
      put(34 + o, sp[15:8]); put(35 + o, sp[7:0]);
      put(36 + o, dp[15:8]); put(37 + o, dp[7:0]);
      put(47 + o, fl);
    end
  endtask

  task automatic send_frame(input int abort);
    int n, nb, to;
    time t_first, t_last;
    n = frm.size();
    nb = (n == 0) ? 1 : (n + NB - 1) / NB;
    t_first = 0;
    t_last = 0;
    for (int bt = 0; bt < nb; bt++) begin
      if (abort > 0 && bt == abort) return;
      @(negedge clk);
      s_valid = 1'b1;
      s_last = (bt == nb - 1);
      for (int l = 0; l < NB; l++) begin
        s_data[8*l +: 8] = (bt*NB + l < n) ? frm[bt*NB + l] : 8'h00;
        s_keep[l] = (bt*NB + l < n);
      end
      to = 0;
      while (!s_ready && to < 300) begin
        @(negedge clk);
        to++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 32'(s_ready), 1);
        s_valid = 1'b0;
        s_last = 1'b0;
        return;
      end
      @(posedge clk);
      if (bt == 0) t_first = $time;
      t_last = $time;
      #1;
      s_valid = 1'b0;
      s_last = 1'b0;
    end
    expq.push_back(model(int'((t_first - t_prev) / 10), seq_exp));
    t_prev = t_last;
    seq_exp++;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while (expq.size() > 0 && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (expq.size() > 0) chk("drain_timeout", 32'(expq.size()), 0);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (n) @(posedge clk);
    t_prev = $time;
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_feat", 32'(|m_feat), 0);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    seq_exp = 0;
  endtask

  always begin
    @(negedge clk);
    #4;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_vector", 32'(m_valid), 0);
      end else begin
        e = expq.pop_front();
        for (int k = 0; k < 20; k++)
          chk($sformatf("feat%0d", k), m_feat[k*FW +: FW], e[k*FW +: FW]);
        last_feat = m_feat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20*FW-1:0] held;
    logic seen;
    do_reset(5);

    chk("t1_m_valid_idle", 32'(m_valid), 0);
    build(60, 16'h0800, 8'd6, -1, 16'h0400, 16'h0050, 8'h12);
    send_frame(0);
    @(negedge clk);
    chk("t1_m_valid_latency", 32'(m_valid), 1);
    drain();
    chk("t1_f0", lf(0), 1);
    chk("t1_f1", lf(1), 6);
    chk("t1_f8", lf(8), 32'h12);
    chk("t1_f9", lf(9), 60);
    chk("t1_f10", lf(10), 8);
    chk("t1_f15", lf(15), 6);
    chk("t1_f16", lf(16), 0);
    chk("t1_f19", lf(19), 0);

    build(100, 16'h0800, 8'd17, -1, 16'h1234, 16'h0035, 8'h5A);
    send_frame(0);
    drain();
    chk("t2_f1", lf(1), 32'h11);
    chk("t2_f2", lf(2), 32'h1234);
    chk("t2_f3", lf(3), 32'h0035);
    chk("t2_f8", lf(8), 0);
    chk("t2_f15", lf(15), 58);
    chk("t2_f19", lf(19), 1);

    build(64, 16'h0806, 8'd6, -1, 16'h0, 16'h0, 8'hFF);
    send_frame(0);
    drain();
    chk("t3_f0", lf(0), 0);
    chk("t3_f1", lf(1), 0);
    chk("t3_f8", lf(8), 0);
    chk("t3_f18", lf(18), 32'h0806);
    chk("t3_f9", lf(9), 64);

    m_ready = 1'b0;
    build(80, 16'h0800, 8'd6, -1, 16'h1111, 16'h2222, 8'h18);
    send_frame(0);
    build(72, 16'h0800, 8'd17, -1, 16'h3333, 16'h4444, 8'h00);
    fork
      send_frame(0);
      begin
        @(negedge clk);
        held = m_feat;
        chk("t4_m_valid", 32'(m_valid), 1);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("t4_s_ready", 32'(s_ready), 0);
          chk("t4_hold", 32'(m_feat !== held), 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();
    chk("t4_f9", lf(9), 72);

    build(1600, 16'h0800, 8'd6, -1, 16'h0001, 16'h0002, 8'h10);
    send_frame(0);
    drain();
    chk("t5_f9", lf(9), 1600);
    chk("t5_f16", lf(16), 1);

    build(20, 16'h0000, 8'd0, -1, 16'h0, 16'h0, 8'h0);
    send_frame(0);
    drain();
    chk("t5r_f0", lf(0), 0);
    chk("t5r_f4", lf(4), 0);
    chk("t5r_f5", lf(5), 0);
    chk("t5r_f15", lf(15), 0);

`ifdef PKT_PARSER_VLAN_EN
    build(68, 16'h0800, 8'd6, 100, 16'h0BB8, 16'h0016, 8'h02);
    send_frame(0);
    drain();
    chk("vlan_f14", lf(14), 100);
    chk("vlan_f18", lf(18), 32'h0800);
    chk("vlan_f1", lf(1), 6);
`endif

    build(64, 16'h0800, 8'd6, -1, 16'h5555, 16'h6666, 8'h01);
    send_frame(3);
    do_reset(2);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | m_valid;
    end
    chk("t6_no_m_valid", 32'(seen), 0);
    build(60, 16'h0800, 8'd6, -1, 16'h7777, 16'h8888, 8'h11);
    send_frame(0);
    drain();
    chk("t6_f19", lf(19), 0);
    chk("t6_f9", lf(9), 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
